// File: rtl/mem_ctrl_pkg.sv
// Shared widths, transfer-length codes and FSM encoding for the byte-serial memory controller.
package mem_ctrl_pkg;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // Length codes 2 and 3 both mean a full word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      LEN_BYTE: n = 3'd1;
      LEN_HALF: n = 3'd2;
      LEN_WORD: n = 3'd4;
      default:  n = 3'd4;
    endcase
    return n;
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store requests onto one 8-bit RAM port,
// splitting stores into bytes and assembling/extending loads.
//
// state   | meaning
// ST_IDLE | sample requests; load/store beats fetch
// ST_RD   | cnt = bytes addressed so far; byte cnt-1 is on ram_din this cycle
// ST_WR   | cnt = index of the byte on the port; ram_wr_q marks a real write
// ST_FIN  | done pulse; requests ignored
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_PREFIX = 2'b11
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  io_buffer_full,
  input  logic                  if_read,
  input  logic [MEM_ADDR_W-1:0] if_addr,
  output logic [MEM_DATA_W-1:0] if_data,
  output logic                  if_done,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_signed,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [1:0]            mem_len,
  input  logic [MEM_DATA_W-1:0] mem_w_data,
  output logic [MEM_DATA_W-1:0] mem_r_data,
  output logic                  mem_done,
  input  logic [7:0]            ram_din,
  output logic [7:0]            ram_dout,
  output logic [MEM_ADDR_W-1:0] ram_a,
  output logic                  ram_wr
);

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [2:0]              nbytes_q, nbytes_d;
  logic                    is_if_q, is_if_d;
  logic                    zext_q, zext_d;
  logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
  logic [MEM_DATA_W-1:0]   wdata_q, wdata_d;
  logic [MEM_DATA_W-1:0]   asm_q, asm_d;
  logic                    skip_q, skip_d;
  logic                    resume_q, resume_d;
  logic [MEM_ADDR_W-1:0]   ram_a_q, ram_a_d;
  logic [7:0]              ram_dout_q, ram_dout_d;
  logic                    ram_wr_q, ram_wr_d;
  logic                    mem_done_q, mem_done_d;
  logic                    if_done_q, if_done_d;
  logic [MEM_DATA_W-1:0]   mem_r_data_q, mem_r_data_d;
  logic [MEM_DATA_W-1:0]   if_data_q, if_data_d;

  logic [MEM_ADDR_W-1:0]   wr_base, wr_a;
  logic [MEM_DATA_W-1:0]   wr_src;
  logic [2:0]              wr_idx;
  logic                    wr_hold;
  logic [7:0]              wr_byte;
  logic [1:0]              lane;

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] n,
                                         input logic zext);
    logic [31:0] r;
    case (n)
      3'd1:    r = {{24{raw[7] & ~zext}}, raw[7:0]};
      3'd2:    r = {{16{raw[15] & ~zext}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    nbytes_d     = nbytes_q;
    is_if_d      = is_if_q;
    zext_d       = zext_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    asm_d        = asm_q;
    skip_d       = skip_q;
    resume_d     = resume_q;
    ram_a_d      = ram_a_q;
    ram_dout_d   = ram_dout_q;
    ram_wr_d     = 1'b0;
    mem_done_d   = mem_done_q;
    if_done_d    = if_done_q;
    mem_r_data_d = mem_r_data_q;
    if_data_d    = if_data_q;

    // Next store byte: after a real write move on, otherwise retry the same byte.
    wr_base = (state_q == ST_IDLE) ? mem_addr : addr_q;
    wr_src  = (state_q == ST_IDLE) ? mem_w_data : wdata_q;
    if (state_q == ST_WR) wr_idx = ram_wr_q ? cnt_q + 3'd1 : cnt_q;
    else                  wr_idx = 3'd0;
    wr_a    = wr_base + {29'd0, wr_idx};
    wr_hold = (wr_a[17:16] == IO_PREFIX) && io_buffer_full;
    wr_byte = wr_src[{wr_idx[1:0], 3'b000} +: 8];
    lane    = cnt_q[1:0] - 2'd1;

    if (!rdy_in) begin
      resume_d = 1'b1;
    end else begin
      resume_d   = 1'b0;
      ram_dout_d = 8'h00;
      case (state_q)
        ST_IDLE: begin
          if (mem_read || mem_write) begin
            is_if_d  = 1'b0;
            nbytes_d = len_bytes(mem_len);
            addr_d   = mem_addr;
            wdata_d  = mem_w_data;
            zext_d   = mem_signed;
            cnt_d    = 3'd0;
            asm_d    = '0;
            skip_d   = 1'b0;
            ram_a_d  = mem_addr;
            if (mem_write) begin
              state_d    = ST_WR;
              ram_wr_d   = !wr_hold;
              ram_dout_d = wr_hold ? 8'h00 : wr_byte;
            end else begin
              state_d = ST_RD;
            end
          end else if (if_read) begin
            is_if_d  = 1'b1;
            nbytes_d = 3'd4;
            addr_d   = if_addr;
            zext_d   = 1'b0;
            cnt_d    = 3'd0;
            asm_d    = '0;
            skip_d   = 1'b0;
            ram_a_d  = if_addr;
            state_d  = ST_RD;
          end
        end
        ST_RD: begin
          // After a freeze ram_din reflects the held address, so step back and re-issue the pending byte.
          if (resume_q && cnt_q != 3'd0) begin
            cnt_d   = cnt_q - 3'd1;
            ram_a_d = addr_q + {29'd0, cnt_q - 3'd1};
            skip_d  = 1'b1;
          end else begin
            skip_d = 1'b0;
            if (cnt_q != 3'd0 && !skip_q) asm_d[{lane, 3'b000} +: 8] = ram_din;
            if (cnt_q == nbytes_q && !skip_q) begin
              state_d = ST_FIN;
              if (is_if_q) begin
                if_done_d = 1'b1;
                if_data_d = asm_d;
              end else begin
                mem_done_d   = 1'b1;
                mem_r_data_d = extend(asm_d, nbytes_q, zext_q);
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
              if (cnt_q + 3'd1 < nbytes_q) ram_a_d = addr_q + {29'd0, cnt_q + 3'd1};
            end
          end
        end
        ST_WR: begin
          if (ram_wr_q && (cnt_q + 3'd1 == nbytes_q)) begin
            state_d    = ST_FIN;
            mem_done_d = 1'b1;
          end else begin
            cnt_d      = wr_idx;
            ram_a_d    = wr_a;
            ram_wr_d   = !wr_hold;
            ram_dout_d = wr_hold ? 8'h00 : wr_byte;
          end
        end
        ST_FIN: begin
          state_d      = ST_IDLE;
          mem_done_d   = 1'b0;
          if_done_d    = 1'b0;
          mem_r_data_d = '0;
          if_data_d    = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      nbytes_q     <= '0;
      is_if_q      <= 1'b0;
      zext_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      asm_q        <= '0;
      skip_q       <= 1'b0;
      resume_q     <= 1'b0;
      ram_a_q      <= '0;
      ram_dout_q   <= '0;
      ram_wr_q     <= 1'b0;
      mem_done_q   <= 1'b0;
      if_done_q    <= 1'b0;
      mem_r_data_q <= '0;
      if_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nbytes_q     <= nbytes_d;
      is_if_q      <= is_if_d;
      zext_q       <= zext_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      asm_q        <= asm_d;
      skip_q       <= skip_d;
      resume_q     <= resume_d;
      ram_a_q      <= ram_a_d;
      ram_dout_q   <= ram_dout_d;
      ram_wr_q     <= ram_wr_d;
      mem_done_q   <= mem_done_d;
      if_done_q    <= if_done_d;
      mem_r_data_q <= mem_r_data_d;
      if_data_q    <= if_data_d;
    end
  end

  assign ram_a      = ram_a_q;
  assign ram_dout   = ram_dout_q;
  assign ram_wr     = ram_wr_q;
  assign mem_done   = mem_done_q;
  assign if_done    = if_done_q;
  assign mem_r_data = mem_r_data_q;
  assign if_data    = if_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed vector table, hand sequences and a random
// load/store mix checked against a byte-array reference model.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        io_buffer_full;
  logic        if_read;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_read;
  logic        mem_write;
  logic        mem_signed;
  logic [31:0] mem_addr;
  logic [1:0]  mem_len;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;
  logic        mem_done;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .io_buffer_full(io_buffer_full),
    .if_read(if_read), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_signed(mem_signed),
    .mem_addr(mem_addr), .mem_len(mem_len), .mem_w_data(mem_w_data),
    .mem_r_data(mem_r_data), .mem_done(mem_done),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk_in = ~clk_in;

  // Initial RAM image: a few fixed bytes, everything else a hash of the address.
  function automatic logic [7:0] image(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h11;
      32'h0000_0101: return 8'h22;
      32'h0000_0102: return 8'h33;
      32'h0000_0103: return 8'h44;
      32'h0000_0400: return 8'h80;
      32'h0000_0500: return 8'h34;
      32'h0000_0501: return 8'h92;
      32'hFFFF_FFFE: return 8'hAA;
      32'hFFFF_FFFF: return 8'hBB;
      32'h0000_0000: return 8'hCC;
      32'h0000_0001: return 8'hDD;
      default:       return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  typedef struct { int cyc; logic [31:0] a; logic [7:0] d; } wrec_t;

  logic [7:0]  ram_mem [int unsigned];
  logic [7:0]  model_mem [int unsigned];
  wrec_t       wlog [$];
  int          cyc = 0;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : image(a);
  endfunction

  always @(posedge clk_in) begin
    ram_din <= ram_rd(ram_a);
    if (ram_wr) begin
      ram_mem[ram_a] = ram_dout;
      wlog.push_back('{cyc: cyc, a: ram_a, d: ram_dout});
    end
    cyc++;
  end

  function automatic int nb(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [7:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : image(a);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input bit zext);
    logic [63:0] v;
    v = 64'd0;
    for (int k = 0; k < n; k++) v = v | (64'(model_rd(a + 32'(k))) << (8 * k));
    if (n < 4 && !zext && v[8 * n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v[31:0];
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Raise a load/store at the current negedge (cycle T) and wait for mem_done; lat = cycles after T.
  task automatic run_req(input bit wr, input logic [31:0] addr, input logic [1:0] len,
                         input bit zext, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int lat, output int t0);
    mem_read   = !wr;
    mem_write  = wr;
    mem_addr   = addr;
    mem_len    = len;
    mem_signed = zext;
    mem_w_data = wdata;
    t0    = cyc;
    lat   = -1;
    rdata = '0;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(negedge clk_in);
      if (mem_done) begin
        lat   = i;
        rdata = mem_r_data;
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  len;
    bit          zext;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, fetched;
    int lat, t0, widx, n, md, id, seen;
    logic [8:0] wrp;

    vecs[0] = '{1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'h0, 32'h4433_2211, 6};
    vecs[1] = '{1'b0, 32'h0000_0400, 2'd0, 1'b0, 32'h0, 32'hFFFF_FF80, 3};
    vecs[2] = '{1'b0, 32'h0000_0400, 2'd0, 1'b1, 32'h0, 32'h0000_0080, 3};
    vecs[3] = '{1'b0, 32'h0000_0500, 2'd1, 1'b0, 32'h0, 32'hFFFF_9234, 4};
    vecs[4] = '{1'b0, 32'h0000_0500, 2'd1, 1'b1, 32'h0, 32'h0000_9234, 4};
    vecs[5] = '{1'b1, 32'h0000_0203, 2'd1, 1'b0, 32'h0000_BEEF, 32'h0, 3};
    vecs[6] = '{1'b0, 32'h0000_0203, 2'd1, 1'b1, 32'h0, 32'h0000_BEEF, 4};
    vecs[7] = '{1'b0, 32'hFFFF_FFFE, 2'd2, 1'b0, 32'h0, 32'hDDCC_BBAA, 6};
    vecs[8] = '{1'b0, 32'h0000_0100, 2'd3, 1'b0, 32'h0, 32'h4433_2211, 6};
    vecs[9] = '{1'b0, 32'h0000_0102, 2'd1, 1'b0, 32'h0, 32'h0000_4433, 4};

    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
    if_read = 1'b0; if_addr = '0;
    mem_read = 1'b0; mem_write = 1'b0; mem_signed = 1'b0;
    mem_addr = '0; mem_len = '0; mem_w_data = '0;
    repeat (3) @(negedge clk_in);
    check("reset_ram_a", ram_a, 32'h0);
    check("reset_ctrl", {24'h0, ram_dout}, 32'h0);
    check("reset_flags", {29'h0, ram_wr, mem_done, if_done}, 32'h0);
    check("reset_data", mem_r_data | if_data, 32'h0);
    rst_in = 1'b0;
    @(negedge clk_in);

    for (int v = 0; v < NV; v++) begin
      widx = wlog.size();
      run_req(vecs[v].wr, vecs[v].addr, vecs[v].len, vecs[v].zext, vecs[v].wdata, rd, lat, t0);
      check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
      if (!vecs[v].wr) begin
        check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rd);
      end else begin
        n = nb(vecs[v].len);
        check($sformatf("vec%0d_nwrites", v), wlog.size() - widx, n);
        for (int k = 0; k < n && widx + k < wlog.size(); k++) begin
          check($sformatf("vec%0d_wr%0d_cycle", v, k), wlog[widx + k].cyc, t0 + 1 + k);
          check($sformatf("vec%0d_wr%0d_addr", v, k), wlog[widx + k].a, vecs[v].addr + 32'(k));
          check($sformatf("vec%0d_wr%0d_data", v, k), {24'h0, wlog[widx + k].d},
                {24'h0, vecs[v].wdata[8 * k +: 8]});
        end
      end
      @(negedge clk_in);
      check($sformatf("vec%0d_done_low", v), {30'h0, mem_done, if_done}, 32'h0);
    end

    // Store and fetch raised together: store first, fetch starts from IDLE after FIN.
    mem_write = 1'b1; mem_addr = 32'h600; mem_len = 2'd2; mem_w_data = 32'h1122_3344;
    if_read = 1'b1; if_addr = 32'h600;
    md = -1; id = -1; fetched = '0;
    for (int i = 1; i <= 40 && id < 0; i++) begin
      @(negedge clk_in);
      if (mem_done && md < 0) begin md = i; mem_write = 1'b0; end
      if (if_done) begin id = i; fetched = if_data; if_read = 1'b0; end
    end
    mem_write = 1'b0; if_read = 1'b0;
    check("arb_store_done", md, 5);
    check("arb_fetch_done", id, 12);
    check("arb_fetch_data", fetched, 32'h1122_3344);
    @(negedge clk_in);
    check("arb_if_done_low", {31'h0, if_done}, 32'h0);

    // IO store held while the buffer is full.
    widx = wlog.size(); t0 = cyc;
    mem_write = 1'b1; mem_addr = 32'h0003_0000; mem_len = 2'd0; mem_w_data = 32'h0000_00A5;
    io_buffer_full = 1'b1;
    md = -1; wrp = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_in);
      wrp[i] = ram_wr;
      if (i == 3) io_buffer_full = 1'b0;
      if (mem_done && md < 0) begin md = i; mem_write = 1'b0; end
    end
    mem_write = 1'b0;
    check("io_wr_pattern", {23'h0, wrp}, 32'h0000_0010);
    check("io_done", md, 5);
    check("io_nwrites", wlog.size() - widx, 1);
    if (wlog.size() > widx) begin
      check("io_wr_addr", wlog[widx].a, 32'h0003_0000);
      check("io_wr_cycle", wlog[widx].cyc, t0 + 4);
    end

    // Reset in the middle of a word read.
    mem_read = 1'b1; mem_addr = 32'h100; mem_len = 2'd2; mem_signed = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    check("midrst_ram_a", ram_a, 32'h0);
    check("midrst_flags", {23'h0, ram_dout, ram_wr}, 32'h0);
    check("midrst_done", {30'h0, mem_done, if_done}, 32'h0);
    mem_read = 1'b0;
    seen = 0;
    repeat (2) begin @(negedge clk_in); if (mem_done) seen++; end
    rst_in = 1'b0;
    repeat (6) begin @(negedge clk_in); if (mem_done) seen++; end
    check("midrst_no_done", seen, 0);
    run_req(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, rd, lat, t0);
    check("postrst_latency", lat, 6);
    check("postrst_rdata", rd, 32'h4433_2211);
    @(negedge clk_in);

    // Freeze in the middle of a word read: address holds, data still assembles correctly.
    mem_read = 1'b1; mem_addr = 32'h100; mem_len = 2'd2; mem_signed = 1'b0;
    md = -1; rd = '0;
    for (int i = 1; i <= 40 && md < 0; i++) begin
      @(negedge clk_in);
      if (i == 2) rdy_in = 1'b0;
      if (i == 4) check("freeze_ram_a", ram_a, 32'h101);
      if (i == 5) rdy_in = 1'b1;
      if (mem_done) begin md = i; rd = mem_r_data; end
    end
    mem_read = 1'b0; rdy_in = 1'b1;
    check("freeze_completes", {31'h0, md > 0}, 32'h1);
    check("freeze_rdata", rd, 32'h4433_2211);
    @(negedge clk_in);

    // Random loads/stores against the byte-array model.
    for (int it = 0; it < 40; it++) begin
      bit          wr, z;
      logic [1:0]  len;
      logic [31:0] a, wd, exp_rd;
      int          nn;
      wr  = 1'($urandom_range(0, 1));
      z   = 1'($urandom_range(0, 1));
      len = 2'($urandom_range(0, 3));
      a   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                        : 32'h0000_1000 + 32'($urandom_range(0, 63));
      wd  = $urandom;
      nn  = nb(len);
      exp_rd = model_load(a, nn, z);
      run_req(wr, a, len, z, wd, rd, lat, t0);
      if (wr) begin
        check($sformatf("rnd%0d_st_latency", it), lat, nn + 1);
        for (int k = 0; k < nn; k++) begin
          model_mem[a + 32'(k)] = wd[8 * k +: 8];
          check($sformatf("rnd%0d_st_byte%0d", it, k), {24'h0, ram_rd(a + 32'(k))},
                {24'h0, model_rd(a + 32'(k))});
        end
      end else begin
        check($sformatf("rnd%0d_ld_latency", it), lat, nn + 2);
        check($sformatf("rnd%0d_ld_data", it), rd, exp_rd);
      end
      @(negedge clk_in);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
